// File: rtl/mem_responder.sv
// mem_responder: line-granular backing store sitting below the last cache level.
// Captures one line read or writeback request, waits a programmable number of
// clock edges to model DRAM latency, then answers with a one-cycle valid strobe.
// The requester must drop its request before another transaction is accepted,
// so a held request is never serviced twice.

module mem_responder #(
    parameter int ADDRBITS  = 32,
    parameter int WORDBITS  = 32,
    parameter int LINEITEMS = 16,
    parameter int DEPTH     = 1024,
    parameter int LATENCY   = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            request,
    input  logic                            write,
    input  logic [ADDRBITS-1:0]             address,
    input  logic [LINEITEMS*WORDBITS-1:0]   wdata,
    output logic                            valid,
    output logic [LINEITEMS*WORDBITS-1:0]   rdata,
    output logic                            error,
    output logic                            busy
);

    localparam int LINEBITS = LINEITEMS * WORDBITS;
    localparam int IDXBITS  = $clog2(DEPTH);
    localparam int OFFBITS  = $clog2(LINEBITS / 8);
    localparam int HIGHLSB  = OFFBITS + IDXBITS;
    localparam logic [7:0] CNTLOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND,
        RELEASE
    } state_t;

    state_t               state_q;
    logic [7:0]           count_q;
    logic                 holdWrite_q;
    logic                 holdErr_q;
    logic [IDXBITS-1:0]   holdIdx_q;
    logic [LINEBITS-1:0]  holdData_q;
    logic                 valid_q;
    logic                 error_q;
    logic                 busy_q;
    logic [LINEBITS-1:0]  rdata_q;

    // Storage is zero at power-up and deliberately untouched by reset.
    logic [LINEBITS-1:0]  mem [DEPTH] = '{default: '0};

    logic [IDXBITS-1:0]   reqIdx;
    logic                 reqOutOfRange;
    logic [7:0]           countDec;
    logic                 commit;
    logic                 unusedOffset;

    // Line index comes from the bits just above the byte offset; anything set
    // above the index field addresses memory that does not exist.
    assign reqIdx        = address[OFFBITS +: IDXBITS];
    assign reqOutOfRange = (address >> HIGHLSB) != '0;
    assign unusedOffset  = ^address[OFFBITS-1:0];
    assign countDec      = count_q - 8'd1;

    // A writeback lands on the edge that leaves RESPOND, unless reset wins that edge.
    assign commit = reset && (state_q == RESPOND) && holdWrite_q && !holdErr_q;

    // Transaction sequencer: capture, count down latency, respond for one cycle,
    // then hold off until the requester lets go of request.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            holdWrite_q <= 1'b0;
            holdErr_q   <= 1'b0;
            holdIdx_q   <= '0;
            holdData_q  <= '0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
            rdata_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (request) begin
                        holdWrite_q <= write;
                        holdErr_q   <= reqOutOfRange;
                        holdIdx_q   <= reqIdx;
                        holdData_q  <= wdata;
                        count_q     <= CNTLOAD;
                        busy_q      <= 1'b1;
                        state_q     <= (LATENCY == 1) ? RESPOND : WAIT;
                    end
                end
                WAIT: begin
                    count_q <= countDec;
                    if (countDec == 8'd0) begin
                        state_q <= RESPOND;
                    end
                end
                RESPOND: begin
                    valid_q <= 1'b1;
                    error_q <= holdErr_q;
                    rdata_q <= (holdErr_q || holdWrite_q) ? '0 : mem[holdIdx_q];
                    state_q <= RELEASE;
                end
                RELEASE: begin
                    if (!request) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Line storage write port.
    always_ff @(posedge clock) begin
        if (commit) begin
            mem[holdIdx_q] <= holdData_q;
        end
    end

    assign valid = valid_q;
    assign rdata = rdata_q;
    assign error = error_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: drives two responders (latency 4 and latency 1) with
// directed and random line transactions and compares every cycle against a
// transaction-level model built from edge arithmetic and an associative memory.

module tb_mem_responder;

    localparam int LINEBITS  = 512;
    localparam int LINEBYTES = 64;
    localparam int DEPTH     = 1024;

    typedef logic [LINEBITS-1:0] line_t;

    logic        clock;
    logic        reset;
    logic        request [2];
    logic        write   [2];
    logic [31:0] address [2];
    line_t       wdata   [2];
    logic        valid   [2];
    line_t       rdata   [2];
    logic        error   [2];
    logic        busy    [2];

    int checks    = 0;
    int errors    = 0;
    int edgeCnt   = 0;
    bit modelLive = 0;

    // Reference model: memory contents keyed by instance and line, plus the
    // edge number at which the outstanding transaction must answer.
    line_t mm [int];
    bit    inflight    [2];
    bit    releaseWait [2];
    int    respEdge    [2];
    bit    mWrite      [2];
    bit    mErr        [2];
    int    mKey        [2];
    line_t mData       [2];
    bit    expValid    [2];
    bit    expBusy     [2];
    bit    expErr      [2];
    line_t expRdata    [2];

    mem_responder #(.LATENCY(4)) dut4 (
        .clock   (clock),
        .reset   (reset),
        .request (request[0]),
        .write   (write[0]),
        .address (address[0]),
        .wdata   (wdata[0]),
        .valid   (valid[0]),
        .rdata   (rdata[0]),
        .error   (error[0]),
        .busy    (busy[0])
    );

    mem_responder #(.LATENCY(1)) dut1 (
        .clock   (clock),
        .reset   (reset),
        .request (request[1]),
        .write   (write[1]),
        .address (address[1]),
        .wdata   (wdata[1]),
        .valid   (valid[1]),
        .rdata   (rdata[1]),
        .error   (error[1]),
        .busy    (busy[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int latOf(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // 1024 lines of 64 bytes cover byte addresses below 64 KiB.
    function automatic bit outOfRange(input logic [31:0] a);
        return a >= 32'h0001_0000;
    endfunction

    function automatic int lineKey(input int i, input logic [31:0] a);
        return i * DEPTH + int'((a / LINEBYTES) % DEPTH);
    endfunction

    function automatic line_t randLine();
        line_t l;
        for (int w = 0; w < 16; w++) begin
            l[w*32 +: 32] = $urandom;
        end
        return l;
    endfunction

    task automatic checkOutput(input string name, input line_t act, input line_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model update on every rising edge using the inputs that edge sees.
    always @(posedge clock) begin
        edgeCnt++;
        for (int i = 0; i < 2; i++) begin
            expValid[i] = 1'b0;
            expErr[i]   = 1'b0;
            expRdata[i] = '0;
            if (!reset) begin
                inflight[i]    = 1'b0;
                releaseWait[i] = 1'b0;
            end else if (inflight[i] && edgeCnt == respEdge[i]) begin
                expValid[i] = 1'b1;
                if (mErr[i]) begin
                    expErr[i] = 1'b1;
                end else if (mWrite[i]) begin
                    mm[mKey[i]] = mData[i];
                end else begin
                    expRdata[i] = mm.exists(mKey[i]) ? mm[mKey[i]] : '0;
                end
                inflight[i]    = 1'b0;
                releaseWait[i] = 1'b1;
            end else if (releaseWait[i]) begin
                if (!request[i]) releaseWait[i] = 1'b0;
            end else if (!inflight[i] && request[i]) begin
                inflight[i] = 1'b1;
                respEdge[i] = edgeCnt + latOf(i);
                mWrite[i]   = write[i];
                mErr[i]     = outOfRange(address[i]);
                mKey[i]     = lineKey(i, address[i]);
                mData[i]    = wdata[i];
            end
            expBusy[i] = inflight[i] || releaseWait[i];
        end
        modelLive = 1'b1;
    end

    // Every-cycle comparison of both responders against the model.
    always @(negedge clock) begin
        if (modelLive) begin
            for (int i = 0; i < 2; i++) begin
                checkOutput($sformatf("valid[%0d]", i), line_t'(valid[i]), line_t'(expValid[i]));
                checkOutput($sformatf("busy[%0d]", i), line_t'(busy[i]), line_t'(expBusy[i]));
                if (expValid[i]) begin
                    checkOutput($sformatf("error[%0d]", i), line_t'(error[i]), line_t'(expErr[i]));
                    checkOutput($sformatf("rdata[%0d]", i), rdata[i], expRdata[i]);
                end
            end
        end
    end

    // One complete transaction: wait idle, present it, optionally drop early
    // or hold past valid, and report what came back and how many edges it took.
    task automatic applyStimulus(input int i, input bit wr, input logic [31:0] addr,
                                 input line_t data, input int holdExtra, input bit dropEarly,
                                 output line_t got, output logic gotErr, output int latency);
        int n;
        int capEdge;
        got     = '0;
        gotErr  = 1'b0;
        latency = -1;
        n = 0;
        while (busy[i] !== 1'b0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (busy[i] !== 1'b0) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle wait[%0d]: busy stuck at %b", i, busy[i]);
            return;
        end
        request[i] = 1'b1;
        write[i]   = wr;
        address[i] = addr;
        wdata[i]   = data;
        capEdge    = edgeCnt + 1;
        @(negedge clock);
        address[i] = $urandom;
        write[i]   = 1'($urandom_range(0, 1));
        wdata[i]   = randLine();
        if (dropEarly) request[i] = 1'b0;
        n = 0;
        while (valid[i] !== 1'b1 && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (valid[i] !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL valid wait[%0d]: no response within 300 cycles", i);
            request[i] = 1'b0;
            @(negedge clock);
            return;
        end
        got     = rdata[i];
        gotErr  = error[i];
        latency = edgeCnt - capEdge;
        repeat (holdExtra) @(negedge clock);
        request[i] = 1'b0;
        @(negedge clock);
    endtask

    task automatic randomOps(input int i, input int count);
        line_t       got;
        logic        gotErr;
        int          lat;
        logic [31:0] addr;
        int          pick;
        for (int k = 0; k < count; k++) begin
            pick = $urandom_range(0, 9);
            if (pick == 0)
                addr = $urandom | 32'h0001_0000;
            else if (pick < 6)
                addr = ($urandom_range(0, 7) * 64) + $urandom_range(0, 63);
            else
                addr = ($urandom_range(1020, 1023) * 64) + $urandom_range(0, 63);
            applyStimulus(i, 1'($urandom_range(0, 1)), addr, randLine(),
                          $urandom_range(0, 2), $urandom_range(0, 3) == 0, got, gotErr, lat);
            checkInt($sformatf("random latency[%0d]", i), lat, latOf(i));
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int    n;
        int    capEdge;
        int    lat;
        int    pulses;
        line_t got;
        logic  gotErr;
        line_t patA;
        line_t patB;
        line_t patC;
        line_t pat7;
        line_t patD;

        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            request[i] = 1'b0;
            write[i]   = 1'b0;
            address[i] = '0;
            wdata[i]   = '0;
        end
        request[0] = 1'b1;
        address[0] = 32'h0000_0080;

        $display("[TB] reset held with request asserted");
        repeat (3) begin
            @(negedge clock);
            checkOutput("reset valid", line_t'(valid[0]), '0);
            checkOutput("reset busy", line_t'(busy[0]), '0);
        end
        reset   = 1'b1;
        capEdge = edgeCnt + 1;
        @(negedge clock);
        checkOutput("capture after reset", line_t'(busy[0]), line_t'(1));
        n = 0;
        while (valid[0] !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        checkInt("first read latency", edgeCnt - capEdge, 4);
        checkOutput("first read data", rdata[0], '0);
        request[0] = 1'b0;
        @(negedge clock);

        $display("[TB] write then read 0x440");
        patA = {16{32'hA5A5_A5A5}};
        applyStimulus(0, 1'b1, 32'h0000_0440, patA, 0, 1'b0, got, gotErr, lat);
        checkInt("write latency", lat, 4);
        checkOutput("write error", line_t'(gotErr), '0);
        checkOutput("write rdata", got, '0);
        applyStimulus(0, 1'b0, 32'h0000_0440, '0, 0, 1'b0, got, gotErr, lat);
        checkInt("read latency", lat, 4);
        checkOutput("read error", line_t'(gotErr), '0);
        checkOutput("read pattern", got, {16{32'hA5A5_A5A5}});

        $display("[TB] request held for 20 cycles");
        request[0] = 1'b1;
        write[0]   = 1'b0;
        address[0] = 32'h0000_0440;
        pulses     = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (valid[0] === 1'b1) pulses++;
            checkOutput("held busy", line_t'(busy[0]), line_t'(1));
        end
        checkInt("held pulses", pulses, 1);
        request[0] = 1'b0;
        @(negedge clock);
        checkOutput("held release busy", line_t'(busy[0]), '0);

        $display("[TB] out-of-range accesses");
        patB = {16{32'h1234_5678}};
        patC = {16{32'hDEAD_BEEF}};
        applyStimulus(0, 1'b1, 32'h0000_0000, patB, 0, 1'b0, got, gotErr, lat);
        applyStimulus(0, 1'b0, 32'h0010_0000, '0, 0, 1'b0, got, gotErr, lat);
        checkOutput("oor read error", line_t'(gotErr), line_t'(1));
        checkOutput("oor read data", got, '0);
        checkInt("oor read latency", lat, 4);
        applyStimulus(0, 1'b1, 32'h0010_0000, patC, 0, 1'b0, got, gotErr, lat);
        checkOutput("oor write error", line_t'(gotErr), line_t'(1));
        applyStimulus(0, 1'b0, 32'h0000_0000, '0, 0, 1'b0, got, gotErr, lat);
        checkOutput("line 0 after oor write", got, {16{32'h1234_5678}});

        $display("[TB] reset during WAIT and on the RESPOND edge");
        pat7 = {16{32'h0707_0707}};
        applyStimulus(0, 1'b1, 32'h0000_01C0, pat7, 0, 1'b0, got, gotErr, lat);
        request[0] = 1'b1;
        write[0]   = 1'b1;
        address[0] = 32'h0000_01C0;
        wdata[0]   = '1;
        repeat (2) @(negedge clock);
        reset      = 1'b0;
        request[0] = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        applyStimulus(0, 1'b0, 32'h0000_01C0, '0, 0, 1'b0, got, gotErr, lat);
        checkOutput("line 7 after wait reset", got, {16{32'h0707_0707}});
        request[0] = 1'b1;
        write[0]   = 1'b1;
        address[0] = 32'h0000_01C0;
        wdata[0]   = '1;
        repeat (4) @(negedge clock);
        reset      = 1'b0;
        request[0] = 1'b0;
        @(negedge clock);
        checkOutput("respond-edge reset valid", line_t'(valid[0]), '0);
        reset = 1'b1;
        @(negedge clock);
        applyStimulus(0, 1'b0, 32'h0000_01C0, '0, 0, 1'b0, got, gotErr, lat);
        checkOutput("line 7 after respond reset", got, {16{32'h0707_0707}});
        applyStimulus(0, 1'b1, 32'h0000_01C0, '1, 0, 1'b0, got, gotErr, lat);
        applyStimulus(0, 1'b0, 32'h0000_01C0, '0, 0, 1'b0, got, gotErr, lat);
        checkOutput("line 7 committed", got, {16{32'hFFFF_FFFF}});

        $display("[TB] highest line index");
        patD = {16{32'hC0DE_F00D}};
        applyStimulus(0, 1'b1, 32'h0000_FFC0, patD, 0, 1'b0, got, gotErr, lat);
        applyStimulus(0, 1'b0, 32'h0000_FFFF, '0, 0, 1'b0, got, gotErr, lat);
        checkOutput("line 1023 data", got, {16{32'hC0DE_F00D}});
        checkOutput("line 1023 error", line_t'(gotErr), '0);
        applyStimulus(0, 1'b0, 32'h0000_0000, '0, 0, 1'b0, got, gotErr, lat);
        checkOutput("line 0 untouched", got, {16{32'h1234_5678}});

        $display("[TB] random traffic");
        randomOps(0, 40);
        randomOps(1, 100);

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
